cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Shares the single 256-bit physical memory port between the instruction-cache miss path and the data-cache miss/writeback path.
//  Sits between both caches and main memory.
//  Round-robin grant; one transaction in flight at a time.
//  Address/wdata are captured at grant, and the response is routed back to the owning cache only.
// PARAMETERS
//  ADDR_W  32   physical address width
//  LINE_W  256  cache line width (bits)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  i_address  in   ADDR_W  icache line address (offset bits 0)
//  i_read     in   1       icache fill request; held until i_resp
//  i_rdata    out  LINE_W  fill data to icache (valid when i_resp)
//  i_resp     out  1       icache transaction done, 1-cycle pulse
//  d_address  in   ADDR_W  dcache line address
//  d_wdata    in   LINE_W  dcache writeback line
//  d_read     in   1       dcache fill request; held until d_resp
//  d_write    in   1       dcache writeback request; held until d_resp
//  d_rdata    out  LINE_W  fill data to dcache
//  d_resp     out  1       dcache transaction done, 1-cycle pulse
//  mem_address out ADDR_W  registered address to memory
//  mem_wdata  out  LINE_W  registered write line
//  mem_read   out  1       memory read strobe, held until mem_resp
//  mem_write  out  1       memory write strobe, held until mem_resp
//  mem_rdata  in   LINE_W  memory read line
//  mem_resp   in   1       memory done, 1-cycle pulse
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=I (so D wins the first tie).
//   All outputs 0: mem_read/mem_write, mem_address, mem_wdata, i_resp, d_resp.
//  States: IDLE -> GNT_I | GNT_D -> RELEASE -> IDLE.
//  IDLE, edge N: I pending = i_read. D pending = d_read|d_write.
//   One pending: grant it.
//   Both pending: grant the one != last_grant.
//   On grant, register mem_address/mem_wdata from the winner.
//   mem_read/mem_write go high at N+1. last_grant updates on grant.
//  D with d_read & d_write both high: issue the write only.
//   The read re-arbitrates after RELEASE.
//  GNT_x: hold mem_* stable, ignore all client inputs.
//   On mem_resp (cycle M): pulse x_resp combinationally in cycle M.
//   x_rdata = mem_rdata. mem_read/mem_write drop at edge M+1. Enter RELEASE.
//  RELEASE: exactly 1 cycle. The just-served client's request is masked.
//   This absorbs its registered request lagging one cycle.
//   The other client may be granted from IDLE at M+2.
//  Latency (memory taking L cycles): request -> strobe 1 cycle.
//   Back-to-back grants are spaced at minimum L+2 cycles.
//  i_rdata/d_rdata: pass mem_rdata unconditionally. Only x_resp qualifies them.
//  mem_resp in IDLE/RELEASE: ignored; no client resp.
//  i_resp and d_resp are never high in the same cycle.
//  mem_read and mem_write are never both high.
//  rst mid-transaction: next edge -> IDLE, strobes low, no resp issued.
//   Memory is reset with the same rst.
//  A request deasserted before grant is simply not served. No latching before grant.
// STRUCTURE
//  Shared package cache_types: LINE_W/ADDR_W localparams.
//   Also arb_state_t enum {IDLE,GNT_I,GNT_D,RELEASE}.
//  Sub-module arb_rr_pick2: 2-way round-robin picker.
//   Inputs: req[1:0], last. Outputs: one-hot gnt[1:0].
//  Top holds the FSM, capture registers and response steering.
// TESTING
//  1. Reset, only i_read=1 @0x0000_1000, mem resp after 5 cycles:
//     mem_read=1 with mem_address=0x1000 one cycle after request.
//     i_resp with i_rdata=mem_rdata; d_resp stays 0.
//  2. i_read and d_read rise the same cycle after reset:
//     D served first, then I. Second grant >=1 idle cycle after first resp.
//  3. d_write=1, d_read=1, d_wdata=0xA5..A5 @0x2000:
//     mem_write first with mem_wdata=0xA5..A5.
//     Then mem_read @0x2000 after RELEASE. Two d_resp pulses total.
//  4. Client holds its request one cycle past its resp:
//     No duplicate memory transaction issued.
//  5. Spurious mem_resp in IDLE -> no i_resp/d_resp.
//     rst asserted during GNT_D -> strobes 0 next cycle, FSM IDLE, no d_resp.
//  6. Saturating traffic on both clients for 100 transactions:
//     Grants strictly alternate. Never both strobes high; never both resps high.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the cache/memory arbiter.
package cache_types;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and memory port signals around the arbiter.
// master: the caches and memory side; slave: the arbiter.
interface cache_arbiter_if #(
  parameter int unsigned ADDR_W = cache_types::ADDR_W,
  parameter int unsigned LINE_W = cache_types::LINE_W
);

  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    output i_address, i_read,
    input  i_rdata, i_resp,
    output d_address, d_wdata, d_read, d_write,
    input  d_rdata, d_resp,
    input  mem_address, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_resp
  );

  modport slave (
    input  i_address, i_read,
    output i_rdata, i_resp,
    input  d_address, d_wdata, d_read, d_write,
    output d_rdata, d_resp,
    output mem_address, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not last served wins.
// Index 0 = icache, 1 = dcache; last holds the index of the previous grant.
module arb_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant; a lone requester always wins, a tie goes to !last.
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single line-wide memory port between the icache miss path and
// the dcache miss/writeback path. One transaction in flight; address and
// write data are captured at grant, the response goes only to the owner.
module cache_arbiter #(
  parameter int unsigned ADDR_W = cache_types::ADDR_W,
  parameter int unsigned LINE_W = cache_types::LINE_W
) (
  input  logic           clk,
  input  logic           rst,
  cache_arbiter_if.slave bus
);

  import cache_types::*;

  arb_state_t        state_q, state_d;
  logic              last_q;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              grant_i, grant_d;
  logic              resp_i, resp_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              rd_q, wr_q;

  assign req = {bus.d_read | bus.d_write, bus.i_read};

  arb_rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, grant strobes and owner-steered response pulses.
  // Arbitration happens only in IDLE; RELEASE never grants, which keeps the
  // just-served client's lagging request from starting a duplicate.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    resp_i  = 1'b0;
    resp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt[1]) begin
          grant_d = 1'b1;
          state_d = GNT_D;
        end else if (gnt[0]) begin
          grant_i = 1'b1;
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        if (bus.mem_resp) begin
          resp_i  = 1'b1;
          state_d = RELEASE;
        end
      end
      GNT_D: begin
        if (bus.mem_resp) begin
          resp_d  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture winner's address/data at grant, drop strobes on completion.
  // A dcache read+write request issues only the write; the read re-arbitrates.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      last_q  <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= bus.d_address;
      wdata_q <= bus.d_wdata;
      wr_q    <= bus.d_write;
      rd_q    <= ~bus.d_write;
      last_q  <= 1'b1;
    end else if (grant_i) begin
      addr_q  <= bus.i_address;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b1;
      last_q  <= 1'b0;
    end else if (resp_i || resp_d) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;
  assign bus.i_resp      = resp_i;
  assign bus.d_resp      = resp_d;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a small latency-configurable memory model.
module tb_cache_arbiter;

  import cache_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // cycle counter
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: responds after lat strobe cycles, or once on demand (spur)
  int unsigned lat = 5;
  int unsigned mcnt;
  bit spur = 1'b0;
  initial begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    mcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_resp = 1'b0;
      if (rst) begin
        mcnt = 0;
      end else if (spur) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = '1;
      end else if (bus.mem_read || bus.mem_write) begin
        mcnt++;
        if (mcnt == lat) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = line_of(bus.mem_address);
          mcnt = 0;
        end
      end
    end
  end

  // monitor: transaction log, response counts, protocol violations
  logic [31:0]  log_addr[$];
  bit           log_wr[$];
  logic [255:0] log_wdata[$];
  int           log_cyc[$];
  int i_cnt = 0;
  int d_cnt = 0;
  int viol  = 0;
  bit prev_strobe = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.mem_read && bus.mem_write) viol++;
      if (bus.i_resp && bus.d_resp) viol++;
      if ((bus.i_resp || bus.d_resp) && !bus.mem_resp) viol++;
      if ((bus.mem_read || bus.mem_write) && !prev_strobe) begin
        log_addr.push_back(bus.mem_address);
        log_wr.push_back(bus.mem_write);
        log_wdata.push_back(bus.mem_wdata);
        log_cyc.push_back(cyc);
      end
      if (bus.i_resp) begin
        i_cnt++;
        if (log_addr.size() == 0 || !log_addr[$][12]) viol++;
        check("i_rdata", bus.i_rdata, bus.mem_rdata);
      end
      if (bus.d_resp) begin
        d_cnt++;
        if (log_addr.size() == 0 || !log_addr[$][13]) viol++;
        check("d_rdata", bus.d_rdata, bus.mem_rdata);
      end
    end
    prev_strobe = (bus.mem_read || bus.mem_write) && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // call at a negedge; returns cycles waited and the cycle of the response
  task automatic wait_resp(input bit is_d, input string tag, output int k, output int rc);
    k = 0;
    while (!(is_d ? bus.d_resp : bus.i_resp) && k < 40) begin
      @(negedge clk);
      k++;
    end
    rc = cyc;
    check({tag, "_resp_seen"}, (is_d ? bus.d_resp : bus.i_resp), 1'b1);
  endtask

  initial begin
    int k, rc, rq, lb, ib, db, n, same;
    logic [31:0] ia, da;

    // 1: reset values, single icache fill
    do_reset();
    @(negedge clk);
    check("rst_mem_read",  bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr",  bus.mem_address, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 256'h0);
    check("rst_i_resp",    bus.i_resp, 1'b0);
    check("rst_d_resp",    bus.d_resp, 1'b0);
    tick();
    bus.i_address = 32'h0000_1000;
    bus.i_read = 1'b1;
    @(negedge clk);
    check("t1_no_strobe_yet", bus.mem_read, 1'b0);
    @(negedge clk);
    check("t1_mem_read",  bus.mem_read, 1'b1);
    check("t1_mem_write", bus.mem_write, 1'b0);
    check("t1_mem_addr",  bus.mem_address, 32'h0000_1000);
    wait_resp(1'b0, "t1", k, rc);
    check("t1_latency", k, 4);
    check("t1_i_rdata_val", bus.i_rdata, line_of(32'h0000_1000));
    tick();
    bus.i_read = 1'b0;
    @(negedge clk);
    check("t1_strobe_drop", bus.mem_read, 1'b0);
    check("t1_i_count", i_cnt, 1);
    check("t1_d_count", d_cnt, 0);

    // 2: simultaneous requests after reset: D first, then I
    do_reset();
    lb = log_addr.size();
    tick();
    bus.i_address = 32'h0000_1040; bus.i_read = 1'b1;
    bus.d_address = 32'h0000_2040; bus.d_read = 1'b1;
    rq = cyc;
    @(negedge clk);
    wait_resp(1'b1, "t2_d", k, rc);
    tick();
    bus.d_read = 1'b0;
    @(negedge clk);
    wait_resp(1'b0, "t2_i", k, n);
    tick();
    bus.i_read = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_count",      log_addr.size() - lb, 2);
    check("t2_first_addr", log_addr[lb], 32'h0000_2040);
    check("t2_second_addr", log_addr[lb+1], 32'h0000_1040);
    check("t2_req_to_strobe", log_cyc[lb] - rq, 1);
    check("t2_gap_after_resp", log_cyc[lb+1] - rc, 3);

    // 3: dcache read+write: write first, read after release
    do_reset();
    lb = log_addr.size();
    db = d_cnt;
    tick();
    bus.d_address = 32'h0000_2000;
    bus.d_wdata = {32{8'hA5}};
    bus.d_read = 1'b1;
    bus.d_write = 1'b1;
    @(negedge clk);
    wait_resp(1'b1, "t3_wr", k, rc);
    tick();
    bus.d_write = 1'b0;
    @(negedge clk);
    wait_resp(1'b1, "t3_rd", k, rc);
    tick();
    bus.d_read = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_count",     log_addr.size() - lb, 2);
    check("t3_first_wr",  log_wr[lb], 1'b1);
    check("t3_wdata",     log_wdata[lb], {32{8'hA5}});
    check("t3_wr_addr",   log_addr[lb], 32'h0000_2000);
    check("t3_second_wr", log_wr[lb+1], 1'b0);
    check("t3_rd_addr",   log_addr[lb+1], 32'h0000_2000);
    check("t3_spacing",   log_cyc[lb+1] - log_cyc[lb], 7);
    check("t3_d_resps",   d_cnt - db, 2);

    // 4: request held one cycle past its response: no duplicate
    do_reset();
    lb = log_addr.size();
    ib = i_cnt;
    tick();
    bus.i_address = 32'h0000_1080;
    bus.i_read = 1'b1;
    @(negedge clk);
    wait_resp(1'b0, "t4", k, rc);
    tick();
    tick();
    bus.i_read = 1'b0;
    repeat (15) @(negedge clk);
    check("t4_no_dup",   log_addr.size() - lb, 1);
    check("t4_i_resps",  i_cnt - ib, 1);

    // 5a: spurious memory response while idle
    lb = log_addr.size();
    ib = i_cnt;
    db = d_cnt;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    check("t5_spur_i_resp", bus.i_resp, 1'b0);
    check("t5_spur_d_resp", bus.d_resp, 1'b0);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_spur_counts", (i_cnt - ib) + (d_cnt - db), 0);
    check("t5_spur_no_txn", log_addr.size() - lb, 0);

    // 5b: reset in the middle of a dcache grant
    tick();
    bus.d_address = 32'h0000_2100;
    bus.d_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_d_strobe", bus.mem_read, 1'b1);
    tick();
    rst = 1'b1;
    bus.d_read = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_mem_read",  bus.mem_read, 1'b0);
    check("t5_rst_mem_write", bus.mem_write, 1'b0);
    check("t5_rst_d_resp",    bus.d_resp, 1'b0);
    repeat (10) @(negedge clk);
    check("t5_no_d_resp", d_cnt - db, 0);
    check("t5_one_aborted", log_addr.size() - lb, 1);
    tick();
    bus.i_address = 32'h0000_1100;
    bus.i_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_idle_regrant", bus.mem_read, 1'b1);
    check("t5_idle_addr",    bus.mem_address, 32'h0000_1100);
    wait_resp(1'b0, "t5_i", k, rc);
    tick();
    bus.i_read = 1'b0;
    repeat (3) @(negedge clk);

    // 6: saturating traffic, 100 transactions, short memory latency
    do_reset();
    lat = 2;
    lb = log_addr.size();
    ia = 32'h0000_1000;
    da = 32'h0000_2000;
    tick();
    bus.i_address = ia; bus.i_read = 1'b1;
    bus.d_address = da; bus.d_read = 1'b1;
    n = 0;
    k = 0;
    while (n < 100 && k < 2000) begin
      @(negedge clk);
      k++;
      if (bus.i_resp || bus.d_resp) begin
        if (bus.i_resp) begin n++; ia = ia + 32'h40; end
        if (bus.d_resp) begin n++; da = da + 32'h40; end
        tick();
        if (n >= 100) begin
          bus.i_read = 1'b0;
          bus.d_read = 1'b0;
        end else begin
          bus.i_address = ia;
          bus.d_address = da;
        end
      end
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_resp_count", n, 100);
    check("t6_txn_count", log_addr.size() - lb, 100);
    check("t6_first_is_d", log_addr[lb][13], 1'b1);
    same = 0;
    for (int i = lb + 1; i < lb + 100 && i < log_addr.size(); i++)
      if (log_addr[i][13] == log_addr[i-1][13]) same++;
    check("t6_alternate", same, 0);
    check("t6_spacing", log_cyc[lb+99] - log_cyc[lb], 396);
    check("t6_last_d_addr", log_addr[lb+98], 32'h0000_2000 + 32'd49 * 32'h40);
    check("t6_last_i_addr", log_addr[lb+99], 32'h0000_1000 + 32'd49 * 32'h40);

    check("protocol_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
